// File: rtl/exu_arbiter_if.sv
// Handshake and operand bundle between two requesters, the shared EXU
// and the response consumer of exu_arbiter.
interface exu_arbiter_if #(
    parameter int DATAWIDTH = 32
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [DATAWIDTH-1:0] req0_src1;
    logic [DATAWIDTH-1:0] req0_src2;
    logic [DATAWIDTH-1:0] req0_imm;
    logic [3:0]           req0_mode;

    logic                 req1_valid;
    logic                 req1_ready;
    logic [DATAWIDTH-1:0] req1_src1;
    logic [DATAWIDTH-1:0] req1_src2;
    logic [DATAWIDTH-1:0] req1_imm;
    logic [3:0]           req1_mode;

    logic [DATAWIDTH-1:0] exu_rdata1;
    logic [DATAWIDTH-1:0] exu_rdata2;
    logic [DATAWIDTH-1:0] exu_imm;
    logic [3:0]           exu_mode;
    logic [DATAWIDTH-1:0] exu_data;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [DATAWIDTH-1:0] rsp_data;
    logic                 rsp_err;

    modport slave (
        input  req0_valid, req0_src1, req0_src2, req0_imm, req0_mode,
        input  req1_valid, req1_src1, req1_src2, req1_imm, req1_mode,
        input  exu_data, rsp_ready,
        output req0_ready, req1_ready,
        output exu_rdata1, exu_rdata2, exu_imm, exu_mode,
        output rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport master (
        output req0_valid, req0_src1, req0_src2, req0_imm, req0_mode,
        output req1_valid, req1_src1, req1_src2, req1_imm, req1_mode,
        output exu_data, rsp_ready,
        input  req0_ready, req1_ready,
        input  exu_rdata1, exu_rdata2, exu_imm, exu_mode,
        input  rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/exu_arbiter.sv
// Round-robin arbiter sharing one combinational EXU between two requesters,
// with a single registered response slot.
module exu_arbiter #(
    parameter int DATAWIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    exu_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_t;

    state_t               state;
    logic                 last;
    logic                 rsp_valid_q;
    logic                 rsp_id_q;
    logic [DATAWIDTH-1:0] rsp_data_q;
    logic                 rsp_err_q;

    logic                 open_slot;
    logic                 gnt0;
    logic                 gnt1;
    logic                 illegal;
    logic [DATAWIDTH-1:0] sel_src1;
    logic [DATAWIDTH-1:0] sel_src2;
    logic [DATAWIDTH-1:0] sel_imm;
    logic [3:0]           sel_mode;

    // last=1 means requester 1 was granted most recently, so 0 wins a tie
    always_comb begin
        open_slot = rst_n && ((state == IDLE) || bus.rsp_ready);
        gnt0 = open_slot && bus.req0_valid && (!bus.req1_valid || last);
        gnt1 = open_slot && bus.req1_valid && (!bus.req0_valid || !last);
        sel_src1 = '0;
        sel_src2 = '0;
        sel_imm  = '0;
        sel_mode = '0;
        unique case (1'b1)
            gnt0: begin
                sel_src1 = bus.req0_src1;
                sel_src2 = bus.req0_src2;
                sel_imm  = bus.req0_imm;
                sel_mode = bus.req0_mode;
            end
            gnt1: begin
                sel_src1 = bus.req1_src1;
                sel_src2 = bus.req1_src2;
                sel_imm  = bus.req1_imm;
                sel_mode = bus.req1_mode;
            end
            default: ;
        endcase
        illegal = (sel_mode[3:1] == 3'b011) || sel_mode[3] && (sel_mode[2:1] != 2'b00);
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.exu_rdata1 = sel_src1;
    assign bus.exu_rdata2 = sel_src2;
    assign bus.exu_imm    = sel_imm;
    assign bus.exu_mode   = sel_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else if (gnt0 || gnt1) begin
            state       <= HOLD;
            last        <= gnt1;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= gnt1;
            rsp_data_q  <= bus.exu_data;
            rsp_err_q   <= illegal;
        end else if ((state == HOLD) && bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: doc/exu_arbiter.md
EXU_ARBITER -- requirements
Module: exu_arbiter

Interface
REQ-001 Parameter DATAWIDTH, default 32, operand/result width; only 32 supported.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 req0_src1, req0_src2, req0_imm (and req1_*)  input  DATAWIDTH  operands per requester.
REQ-007 req0_mode / req1_mode  input  4  EXU mode per requester: bit0 imm select; bits[3:1] 000 add, 001 sub, 010 unsigned cmp, 100 signed cmp.
REQ-008 exu_rdata1, exu_rdata2, exu_imm  output  DATAWIDTH  operands driven to the shared combinational EXU.
REQ-009 exu_mode  output  4  mode driven to the shared EXU.
REQ-010 exu_data  input  DATAWIDTH  combinational EXU result.
REQ-011 rsp_valid  output  1  registered result available.
REQ-012 rsp_ready  input  1  consumer accepts result.
REQ-013 rsp_id  output  1  requester that owns rsp_data (0 or 1).
REQ-014 rsp_data  output  DATAWIDTH  registered EXU result.
REQ-015 rsp_err  output  1  operation had an illegal mode[3:1] (011, 101, 110, 111).

Function
REQ-016 States: IDLE (no result held), HOLD (result held, rsp_valid=1).
REQ-017 Grant slot open when state is IDLE, or HOLD with rsp_ready=1.
REQ-018 In an open slot with any reqN_valid=1, exactly one requester is granted; reqN_ready=1 only for the granted requester, combinationally, same cycle.
REQ-019 No grant (both ready=0) when slot closed or no valid request; ready never asserted without matching valid.
REQ-020 Arbitration round-robin: single valid request always wins; both valid -> requester not granted last wins; pointer updates only on a grant.
REQ-021 During a grant cycle exu_rdata1/2, exu_imm, exu_mode carry the granted requester's fields; otherwise they are driven to zero (exu_mode=0000).
REQ-022 On a grant edge: rsp_data<=exu_data, rsp_id<=granted index, rsp_err<=illegal-mode flag, state<=HOLD; latency one cycle from accept to rsp_valid.
REQ-023 Illegal mode still consumes a slot; rsp_data is the EXU output (zero) and rsp_err=1.
REQ-024 HOLD with rsp_ready=1 and no grant -> IDLE; rsp_valid falls next cycle.
REQ-025 HOLD with rsp_ready=1 and a grant -> stays HOLD with new result loaded: sustained throughput one op/cycle.
REQ-026 HOLD with rsp_ready=0: rsp_valid, rsp_id, rsp_data, rsp_err held stable; both req ready=0.
REQ-027 Requester may drop valid without being granted; no state change results.
REQ-028 Operands and mode must be stable only in the grant cycle; no operand buffering beyond rsp_data.

Reset
REQ-029 rst_n low asynchronously forces state IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, round-robin pointer = "last granted 1" (requester 0 wins first tie).
REQ-030 Reset mid-HOLD discards the held result; no response emitted after release.
REQ-031 While rst_n low, req0_ready=req1_ready=0 and exu_* outputs are zero.
REQ-032 First grant possible on the first rising edge with rst_n high.

Verification
REQ-033 Req0 only, src1=5, src2=3, mode=0000, rsp_ready=1 -> req0_ready same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=8, rsp_err=0.
REQ-034 Both valid every cycle after reset, rsp_ready=1, req1 sub 10-4 imm path (mode=0011, imm=4) -> grants alternate 0,1,0,1; req1 responses rsp_data=6; one response per cycle.
REQ-035 Req0 unsigned cmp 1 vs 0xFFFFFFFF (mode=0100) then signed cmp same operands (mode=1000) -> rsp_data 0x4 then 0x2.
REQ-036 rsp_ready=0 for 3 cycles with result 0x12 held and req1 valid -> rsp outputs stable, req1_ready=0; on rsp_ready=1 req1 granted same cycle, new result next cycle.
REQ-037 mode=0110 -> one slot consumed, rsp_data=0, rsp_err=1.
REQ-038 rst_n asserted low while HOLD -> rsp_valid drops immediately (asynchronously); after release with no requests, rsp_valid stays 0.
